// File: rtl/bus_sequencer.sv
// Command-queued sequencer driving bus A/B output enables and load strobes for a register bank.
// Optional range checking of popped commands is enabled by defining BUS_SEQ_RANGE_CHECK_EN.
module bus_sequencer #(
  parameter int NREGS     = 6,
  parameter int IDX_W     = 3,
  parameter int OP_CYCLES = 2,
  parameter int DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDX_W-1:0] cmd_src1,
  input  logic [IDX_W-1:0] cmd_src2,
  input  logic [IDX_W-1:0] cmd_dst,
  input  logic             cmd_use_b,
  input  logic             cmd_wr,
  output logic [NREGS-1:0] enable1,
  output logic [NREGS-1:0] enable2,
  output logic [NREGS-1:0] load,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OP_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]   NREGS_W  = (IDX_W + 1)'(NREGS);

`ifdef BUS_SEQ_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef struct packed {
    logic [IDX_W-1:0] src1;
    logic [IDX_W-1:0] src2;
    logic [IDX_W-1:0] dst;
    logic             use_b;
    logic             wr;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_REJ
  } state_t;

  cmd_t             fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t             cur_q, cur_d;
  logic [NREGS-1:0] enable1_q, enable1_d;
  logic [NREGS-1:0] enable2_q, enable2_d;
  logic [NREGS-1:0] load_q, load_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  cmd_t cmd_in;
  cmd_t head;
  logic push, pop, launch_slot, reject, run_d;

  function automatic logic [NREGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREGS-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx == IDX_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < NREGS_W;
  endfunction

  assign cmd_in    = '{cmd_src1, cmd_src2, cmd_dst, cmd_use_b, cmd_wr};
  assign cmd_ready = (count_q != FULL_CNT);
  assign busy      = (state_q != ST_IDLE) || (count_q != '0);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    enable1_d = '0;
    enable2_d = '0;
    load_d    = '0;

    head        = fifo_q[rd_ptr_q];
    push        = cmd_valid && cmd_ready;
    // A new command may launch from idle, after a reject slot, or on the last RUN cycle.
    launch_slot = (state_q == ST_IDLE) || (state_q == ST_REJ) ||
                  ((state_q == ST_RUN) && (cnt_q == LAST_CNT));
    pop         = launch_slot && (count_q != '0);
    reject      = RANGE_CHECK && (!in_range(head.src1) ||
                                  (head.use_b && !in_range(head.src2)) ||
                                  (head.wr && !in_range(head.dst)));

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      cur_d   = head;
      cnt_d   = '0;
      state_d = reject ? ST_REJ : ST_RUN;
    end else if ((state_q == ST_RUN) && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      state_d = ST_IDLE;
    end

    // Strobes are computed from the next state so they can be registered without extra latency.
    run_d  = (state_d == ST_RUN);
    done_d = run_d && (cnt_d == LAST_CNT);
    err_d  = (state_d == ST_REJ);
    if (run_d) begin
      enable1_d = onehot(cur_d.src1);
      if (cur_d.use_b) enable2_d = onehot(cur_d.src2);
    end
    if (done_d && cur_d.wr) load_d = onehot(cur_d.dst);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_q     <= '0;
      enable1_q <= '0;
      enable2_q <= '0;
      load_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      enable1_q <= enable1_d;
      enable2_q <= enable2_d;
      load_q    <= load_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the FIFO storage is not reset; entries are only read after being written, and count guards them.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= cmd_in;
  end

  assign enable1 = enable1_q;
  assign enable2 = enable2_q;
  assign load    = load_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed self-checking bench for bus_sequencer (NREGS=6, IDX_W=3, OP_CYCLES=2, DEPTH=4).
// Expectations follow BUS_SEQ_RANGE_CHECK_EN when it is defined for the build.
module tb_bus_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_src1, cmd_src2, cmd_dst;
  logic       cmd_use_b, cmd_wr;
  logic [5:0] enable1, enable2, load;
  logic       done, busy, err;

  int tests;
  int fails;

  bus_sequencer #(
    .NREGS(6), .IDX_W(3), .OP_CYCLES(2), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .cmd_use_b(cmd_use_b), .cmd_wr(cmd_wr),
    .enable1(enable1), .enable2(enable2), .load(load),
    .done(done), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; outputs are stable there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                           input logic ub, input logic w);
    cmd_valid = 1'b1;
    cmd_src1  = s1;
    cmd_src2  = s2;
    cmd_dst   = d;
    cmd_use_b = ub;
    cmd_wr    = w;
  endtask

  task automatic test_reset();
    logic [19:0] got;
    rst = 1'b1;
    cmd_valid = 1'b0;
    drive_cmd(3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      got = {enable1, enable2, load, done, err};
      tests++;
      if (got !== 20'd0) begin
        fails++;
        $display("FAIL reset_strobes c%0d got %b want 0", c, got);
      end
      tests++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_ready_busy c%0d got ready=%b busy=%b want ready=1 busy=0", c, cmd_ready, busy);
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic [19:0] got, exp;
    drive_cmd(3'd2, 3'd5, 3'd1, 1'b1, 1'b1);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_ready got %b want 1", cmd_ready);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      cmd_valid = 1'b0;
      exp = 20'd0;
      if (c == 2) exp = {6'b000100, 6'b100000, 6'b000000, 1'b0, 1'b0};
      if (c == 3) exp = {6'b000100, 6'b100000, 6'b000010, 1'b1, 1'b0};
      got = {enable1, enable2, load, done, err};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL single_strobes c%0d got %b want %b", c, got, exp);
      end
      tests++;
      if (busy !== (c != 4)) begin
        fails++;
        $display("FAIL single_busy c%0d got %b want %b", c, busy, (c != 4));
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [19:0] got, exp;
    logic [5:0]  one;
    int sent, done_n, first_nr, k;
    one = 6'b000001;
    sent = 0;
    done_n = 0;
    first_nr = -1;
    for (int c = 0; c < 20; c++) begin
      if (sent < 8) drive_cmd(3'(sent % 6), 3'((sent + 3) % 6), 3'((sent + 1) % 6), 1'b1, 1'b1);
      else cmd_valid = 1'b0;
      if (cmd_valid && cmd_ready) sent++;
      if (!cmd_ready && first_nr < 0) first_nr = c;
      if (done === 1'b1) done_n++;
      exp = 20'd0;
      if (c >= 2 && c <= 17) begin
        k = (c - 2) / 2;
        exp[19:14] = one << (k % 6);
        exp[13:8]  = one << ((k + 3) % 6);
        if (c % 2 == 1) begin
          exp[7:2] = one << ((k + 1) % 6);
          exp[1]   = 1'b1;
        end
      end
      got = {enable1, enable2, load, done, err};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL b2b_strobes c%0d got %b want %b", c, got, exp);
      end
      if (c >= 1) begin
        tests++;
        if (busy !== (c <= 17)) begin
          fails++;
          $display("FAIL b2b_busy c%0d got %b want %b", c, busy, (c <= 17));
        end
      end
      tick();
    end
    cmd_valid = 1'b0;
    tests++;
    if (sent != 8) begin
      fails++;
      $display("FAIL b2b_accepted got %0d want 8", sent);
    end
    tests++;
    if (first_nr != 7) begin
      fails++;
      $display("FAIL b2b_ready_drop got cycle %0d want cycle 7", first_nr);
    end
    tests++;
    if (done_n != 8) begin
      fails++;
      $display("FAIL b2b_done_count got %0d want 8", done_n);
    end
  endtask

  task automatic test_no_b_no_wr();
    logic [19:0] got, exp;
    drive_cmd(3'd4, 3'd3, 3'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      cmd_valid = 1'b0;
      exp = 20'd0;
      if (c == 2) exp = {6'b010000, 6'b000000, 6'b000000, 1'b0, 1'b0};
      if (c == 3) exp = {6'b010000, 6'b000000, 6'b000000, 1'b1, 1'b0};
      got = {enable1, enable2, load, done, err};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL nobwr_strobes c%0d got %b want %b", c, got, exp);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [19:0] got, exp;
    drive_cmd(3'd2, 3'd5, 3'd1, 1'b1, 1'b1);
    tick();
    drive_cmd(3'd0, 3'd1, 3'd3, 1'b1, 1'b1);
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    exp = {6'b000100, 6'b100000, 6'b000000, 1'b0, 1'b0};
    got = {enable1, enable2, load, done, err};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL rstmid_run_started got %b want %b", got, exp);
    end
    tick();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_flushed got busy=%b ready=%b want busy=0 ready=1", busy, cmd_ready);
    end
    for (int c = 3; c < 10; c++) begin
      got = {enable1, enable2, load, done, err};
      tests++;
      if (got !== 20'd0) begin
        fails++;
        $display("FAIL rstmid_strobes c%0d got %b want 0", c, got);
      end
      tick();
    end
  endtask

  task automatic test_range();
    logic [19:0] got, exp;
    drive_cmd(3'd7, 3'd0, 3'd2, 1'b0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) drive_cmd(3'd3, 3'd1, 3'd5, 1'b1, 1'b1);
      else cmd_valid = 1'b0;
      exp = 20'd0;
`ifdef BUS_SEQ_RANGE_CHECK_EN
      case (c)
        2: exp = {6'b000000, 6'b000000, 6'b000000, 1'b0, 1'b1};
        3: exp = {6'b001000, 6'b000010, 6'b000000, 1'b0, 1'b0};
        4: exp = {6'b001000, 6'b000010, 6'b100000, 1'b1, 1'b0};
        default: exp = 20'd0;
      endcase
`else
      case (c)
        3: exp = {6'b000000, 6'b000000, 6'b000000, 1'b1, 1'b0};
        4: exp = {6'b001000, 6'b000010, 6'b000000, 1'b0, 1'b0};
        5: exp = {6'b001000, 6'b000010, 6'b100000, 1'b1, 1'b0};
        default: exp = 20'd0;
      endcase
`endif
      got = {enable1, enable2, load, done, err};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL range_strobes c%0d got %b want %b", c, got, exp);
      end
    end
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_no_b_no_wr();
    test_reset_mid_run();
    test_range();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
